// File: rtl/pool2x2_stage.sv
// Streaming 2x2 max-pooling stage: row-major IN_H x IN_W map in, (IN_H/2) x (IN_W/2) maxima out.
// A half-width line buffer carries the top-row pair maxima down to the odd rows.
module pool2x2_stage #(
    parameter int DATA_W = 8,
    parameter int IN_W   = 4,
    parameter int IN_H   = 4,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy,
    output logic              done
);

    localparam int HALF_W   = IN_W / 2;
    localparam int N_OUT    = (IN_W / 2) * (IN_H / 2);
    localparam int COL_W    = $clog2(IN_W);
    localparam int ROW_W    = $clog2(IN_H);
    localparam int BUF_AW   = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_H - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_OUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic                in_done;
    logic [IDX_W-1:0]    res_cnt;
    logic [DATA_W-1:0]   tmp_p0;
    logic [DATA_W-1:0]   line_buf [HALF_W];
    logic [BUF_AW-1:0]   buf_idx;
    logic                accept;

    function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign in_ready = (state == RUN) && !hold && !in_done && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign buf_idx  = BUF_AW'(col >> 1);
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            in_done   <= 1'b0;
            res_cnt   <= '0;
            tmp_p0    <= '0;
            for (int i = 0; i < HALF_W; i++) line_buf[i] <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else if (hold) begin
            // Hold discards any partial frame; out_data is left as-is since out_valid=0.
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            in_done   <= 1'b0;
            res_cnt   <= '0;
            tmp_p0    <= '0;
            for (int i = 0; i < HALF_W; i++) line_buf[i] <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            case (state)
                IDLE:    state <= RUN;
                RUN:     if (out_valid && out_ready && out_idx == IDX_LAST) state <= DONE;
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase

            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                    if (row == ROW_LAST) in_done <= 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                // Window stage: even row builds buffer pairs, odd row folds them into the result.
                case ({row[0], col[0]})
                    2'b00: tmp_p0 <= in_data;
                    2'b01: line_buf[buf_idx] <= max_u(tmp_p0, in_data);
                    2'b10: tmp_p0 <= max_u(line_buf[buf_idx], in_data);
                    default: res_cnt <= res_cnt + 1'b1;
                endcase
            end

            // Output stage: a new result may replace the one being taken on the same edge.
            if (accept && row[0] && col[0]) begin
                out_valid <= 1'b1;
                out_data  <= max_u(tmp_p0, in_data);
                out_idx   <= res_cnt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pool2x2_stage.sv
// Directed bench for pool2x2_stage: table-driven 4x4 streams plus hand-written
// back-pressure, hold, async-reset and held-idle sequences.
module tb_pool2x2_stage;

    logic       clk;
    logic       rst;
    logic       hold;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_idx;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [7:0] pix;
        logic       exp_v;
        logic [1:0] exp_idx;
        logic [7:0] exp_data;
    } vec_t;

    vec_t ramp [16];
    vec_t rev  [16];
    vec_t alt  [16];

    pool2x2_stage #(.DATA_W(8), .IN_W(4), .IN_H(4), .IDX_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Present a pixel until accepted; returns just after the accepting edge.
    task automatic send(input logic [7:0] d, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
    endtask

    task automatic apply(input vec_t v, input string tag, input bit bubble);
        bit ok;
        send(v.pix, ok);
        chk({tag, "_accept"}, 32'(ok), 1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(v.exp_v));
        if (v.exp_v) begin
            chk({tag, "_out_idx"}, 32'(out_idx), 32'(v.exp_idx));
            chk({tag, "_out_data"}, 32'(out_data), 32'(v.exp_data));
        end
        if (bubble) begin
            in_valid = 1'b0;
            in_data  = 8'hAA;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_done(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_out_valid_end"}, 32'(out_valid), 0);
        chk({tag, "_in_ready_end"}, 32'(in_ready), 0);
    endtask

    task automatic restart(input string tag);
        hold = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_hold_busy"}, 32'(busy), 0);
        chk({tag, "_hold_done"}, 32'(done), 0);
        chk({tag, "_hold_out_valid"}, 32'(out_valid), 0);
        hold = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_run_busy"}, 32'(busy), 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ramp[i] = '{pix: 8'(i), exp_v: 1'b0, exp_idx: 2'd0, exp_data: 8'd0};
            rev[i]  = '{pix: 8'(15 - i), exp_v: 1'b0, exp_idx: 2'd0, exp_data: 8'd0};
            alt[i]  = '{pix: ((i / 4) % 2 == 0 && (i % 2) == 0) ? 8'd255 : 8'd0,
                        exp_v: 1'b0, exp_idx: 2'd0, exp_data: 8'd0};
        end
        ramp[5]  = '{pix: 8'd5,  exp_v: 1'b1, exp_idx: 2'd0, exp_data: 8'd5};
        ramp[7]  = '{pix: 8'd7,  exp_v: 1'b1, exp_idx: 2'd1, exp_data: 8'd7};
        ramp[13] = '{pix: 8'd13, exp_v: 1'b1, exp_idx: 2'd2, exp_data: 8'd13};
        ramp[15] = '{pix: 8'd15, exp_v: 1'b1, exp_idx: 2'd3, exp_data: 8'd15};
        rev[5]   = '{pix: 8'd10, exp_v: 1'b1, exp_idx: 2'd0, exp_data: 8'd15};
        rev[7]   = '{pix: 8'd8,  exp_v: 1'b1, exp_idx: 2'd1, exp_data: 8'd13};
        rev[13]  = '{pix: 8'd2,  exp_v: 1'b1, exp_idx: 2'd2, exp_data: 8'd7};
        rev[15]  = '{pix: 8'd0,  exp_v: 1'b1, exp_idx: 2'd3, exp_data: 8'd5};
        alt[5].exp_v  = 1'b1; alt[5].exp_idx  = 2'd0; alt[5].exp_data  = 8'd255;
        alt[7].exp_v  = 1'b1; alt[7].exp_idx  = 2'd1; alt[7].exp_data  = 8'd255;
        alt[13].exp_v = 1'b1; alt[13].exp_idx = 2'd2; alt[13].exp_data = 8'd255;
        alt[15].exp_v = 1'b1; alt[15].exp_idx = 2'd3; alt[15].exp_data = 8'd255;

        rst = 1'b0; hold = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_idx", 32'(out_idx), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        hold = 1'b0;
        @(posedge clk);
        #1;
        chk("start_busy", 32'(busy), 1);
        chk("start_in_ready", 32'(in_ready), 1);

        // Ramp 0..15, back-to-back, always ready.
        for (int i = 0; i < 16; i++) apply(ramp[i], "ramp", 1'b0);
        in_valid = 1'b0;
        check_done("ramp");
        @(posedge clk);
        #1;
        chk("ramp_done_stays", 32'(done), 1);

        // Back-pressure from the first result onward.
        restart("bp");
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) apply(ramp[i], "bp", 1'b0);
        in_valid = 1'b1;
        in_data  = 8'd6;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 0);
            chk("bp_hold_data", 32'(out_data), 5);
            chk("bp_hold_idx", 32'(out_idx), 0);
            chk("bp_hold_valid", 32'(out_valid), 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 6; i < 16; i++) apply(ramp[i], "bp", 1'b0);
        in_valid = 1'b0;
        check_done("bp");

        // Bubbles between every pixel.
        restart("alt");
        for (int i = 0; i < 16; i++) apply(alt[i], "alt", 1'b1);
        check_done("alt");

        // Hold mid-frame after 9 pixels, then a fresh descending frame.
        restart("mid");
        for (int i = 0; i < 9; i++) apply(ramp[i], "mid_pre", 1'b0);
        in_valid = 1'b0;
        restart("mid");
        for (int i = 0; i < 16; i++) apply(rev[i], "rev", 1'b0);
        in_valid = 1'b0;
        check_done("rev");

        // Asynchronous reset mid-frame with a result pending.
        restart("arst");
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) apply(ramp[i], "arst_pre", 1'b0);
        in_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_data", 32'(out_data), 0);
        chk("arst_out_idx", 32'(out_idx), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_run_busy", 32'(busy), 1);
        for (int i = 0; i < 16; i++) apply(ramp[i], "arst_ramp", 1'b0);
        in_valid = 1'b0;
        check_done("arst");

        // Held idle while data is offered.
        hold = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_data = 8'(200 + c);
            @(negedge clk);
            chk("idle_in_ready", 32'(in_ready), 0);
            @(posedge clk);
            #1;
            chk("idle_out_valid", 32'(out_valid), 0);
            chk("idle_busy", 32'(busy), 0);
        end
        in_valid = 1'b0;
        hold = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_release_busy", 32'(busy), 1);
        for (int i = 0; i < 16; i++) apply(ramp[i], "post_idle", 1'b0);
        in_valid = 1'b0;
        check_done("post_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pool2x2_stage.md
Name: pool2x2_stage

Overview:
- Streaming 2x2 max-pooling stage between the 3x3 convolution stage and the display stage of the pipeline.
- Consumes a row-major IN_H x IN_W unsigned feature map over a valid/ready input. Emits the (IN_H/2) x (IN_W/2) pooled map over a valid/ready output with an output index.
- Held idle by the sequencer's per-stage hold line (rst_2b2 from the controller). Starts accepting data when that hold is released.

Parameters:
- DATA_W, 8, pixel width (unsigned), both input and output.
- IN_W, 4, input map width; even, >= 2.
- IN_H, 4, input map height; even, >= 2.
- IDX_W, 2, width of out_idx; must satisfy 2^IDX_W >= (IN_W/2)*(IN_H/2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hold  in  1  synchronous active-high stage hold, driven by the controller's rst_2b2.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  stage can accept a pixel this cycle.
- in_data  in  DATA_W  input pixel.
- out_valid  out  1  pooled result held in output register.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  pooled maximum.
- out_idx  out  IDX_W  row-major index of the pooled result.
- busy  out  1  state RUN.
- done  out  1  all results delivered.

Behaviour:
- Reset (rst=0, async), all outputs and registers cleared:
  - state=IDLE; in_ready=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0.
  - col/row counters and line buffer cleared.
- Accept: a pixel is taken on a rising edge with in_valid && in_ready. Bubbles on in_valid are allowed and change nothing.
- in_ready = (state==RUN) && !hold && pixels_left && (!out_valid || out_ready).
  - This is combinational from out_ready, so a new result may load in the same cycle the old one is taken.
- States and transitions:
  - IDLE -> RUN on the first clock with hold=0.
  - RUN -> DONE on the edge where the last result (idx = N-1, N=(IN_W/2)*(IN_H/2)) transfers (out_valid && out_ready).
  - DONE stays DONE while hold=0. done=1 and in_ready=0 in DONE.
  - Any state -> IDLE on any clock with hold=1. This synchronously clears counters, buffer, out_valid, out_idx and done, including mid-frame; the partial frame is discarded.
- Counters:
  - col runs 0..IN_W-1 and wraps to 0 with row+1.
  - row runs 0..IN_H-1. After row IN_H-1 / col IN_W-1 is accepted, pixels_left=0.
- Pooling datapath, per accepted pixel p at (row, col); unsigned compare; on ties either operand is taken (same value):
  - even row, even col: tmp <= p.
  - even row, odd col: buf[col/2] <= max(tmp, p).
  - odd row, even col: tmp <= max(buf[col/2], p).
  - odd row, odd col: out_data <= max(tmp, p), out_valid <= 1, out_idx <= result counter. The result counter then increments.
- Latency: out_valid rises on the clock edge that accepts the bottom-right pixel of a 2x2 window, and is visible the following cycle.
- Output register:
  - Holds data and idx stable while out_valid && !out_ready.
  - Clears out_valid on transfer unless a new result loads on the same edge.
- Width rules: no arithmetic growth; output width equals input width. buf has IN_W/2 entries of DATA_W.

Test Plan:
- Release hold, stream 4x4 pixels 0..15 back-to-back with out_ready=1 -> results (idx,data) = (0,5), (1,7), (2,13), (3,15). done=1 the cycle after idx 3 transfers; in_ready=0 afterwards.
- Same stream with out_ready held 0 from the first result -> in_ready drops to 0. out_data=5 / out_idx=0 held stable. Raising out_ready resumes with no loss or duplication.
- Input with in_valid toggling every other cycle, values 255,0,0,0 in each window -> all four results = 255. Counters advance only on accepted pixels.
- Assert hold for one cycle after 9 pixels accepted -> out_valid=0, busy=0, done=0. A fresh 16-pixel stream 15..0 then yields (0,15), (1,13), (2,7), (3,5).
- Assert rst=0 asynchronously mid-frame -> all outputs 0 immediately without a clock edge. After rst=1 and hold=0, the stage enters RUN on the next edge.
- With hold=1 held, drive in_valid=1 with data for 20 cycles -> in_ready stays 0, no out_valid, and the state remains IDLE.
